// File: rtl/stream_demux.sv
// 1-to-N valid/ready stream demultiplexer. Each accepted word goes to the channel
// picked by in_sel (mode=0) or by a round-robin pointer (mode=1).

module stream_demux_chan #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);
  // A load wins over a drain, so a drain+load in one cycle keeps valid high with no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module stream_demux #(
  parameter int W    = 8,
  parameter int SELW = 2,
  parameter int N    = 2**SELW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            mode,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [SELW-1:0] rr_ptr,
  output logic [15:0]     xfer_cnt
);
  logic [SELW-1:0]     tgt;
  logic                acc;
  logic [N-1:0]        load;
  logic [N-1:0][W-1:0] chan_data;

  // Readiness looks only at the targeted channel, so a stalled channel never blocks others
  assign tgt      = mode ? rr_ptr : in_sel;
  assign in_ready = ~out_valid[tgt] | out_ready[tgt];
  assign acc      = in_valid & in_ready;
  assign out_data = chan_data;

  for (genvar c = 0; c < N; c++) begin : g_chan
    assign load[c] = acc && (tgt == SELW'(c));
    stream_demux_chan #(.W(W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load    (load[c]),
      .ld_data (in_data),
      .ready   (out_ready[c]),
      .valid   (out_valid[c]),
      .data    (chan_data[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      xfer_cnt <= '0;
    end else if (acc) begin
      xfer_cnt <= xfer_cnt + 16'd1;
      if (mode) rr_ptr <= rr_ptr + SELW'(1);
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: explicit select, drain+load, round-robin wrap,
// stall isolation and mid-operation reset.

module tb_stream_demux;
  localparam int W = 8, SELW = 2, N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [SELW-1:0] in_sel;
  logic            mode;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic [SELW-1:0] rr_ptr;
  logic [15:0]     xfer_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  stream_demux #(.W(W), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .rr_ptr(rr_ptr), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] chd(input int c);
    return out_data[c*W +: W];
  endfunction

  initial begin
    logic [W-1:0] rr_words [5];
    rr_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    rst = 1; in_valid = 0; in_data = 0; in_sel = 0; mode = 0; out_ready = 0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ptr",   32'(rr_ptr),    32'h0);
    chk("rst_cnt",   32'(xfer_cnt),  32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    for (int s = 0; s < N; s++) begin
      in_sel = SELW'(s); #1;
      chk("rst_ready", 32'(in_ready), 32'h1);
    end

    // explicit single word to channel 2
    in_sel = 2; in_data = 8'hA5; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    chk("exp_valid", 32'(out_valid), 32'h4);
    chk("exp_data2", 32'(chd(2)),    32'hA5);
    chk("exp_cnt",   32'(xfer_cnt),  32'h1);
    in_sel = 2; #1;
    chk("exp_rdy_full", 32'(in_ready), 32'h0);
    in_sel = 1; #1;
    chk("exp_rdy_other", 32'(in_ready), 32'h1);

    // back-to-back drain+load on channel 0
    in_sel = 0; out_ready = 4'b0001; in_valid = 1;
    in_data = 8'h11; #1;
    chk("b2b_rdy1", 32'(in_ready), 32'h1);
    tick();
    chk("b2b_v1", 32'(out_valid[0]), 32'h1);
    chk("b2b_d1", 32'(chd(0)), 32'h11);
    in_data = 8'h22; #1;
    chk("b2b_rdy2", 32'(in_ready), 32'h1);
    tick();
    chk("b2b_v2", 32'(out_valid[0]), 32'h1);
    chk("b2b_d2", 32'(chd(0)), 32'h22);
    in_data = 8'h33; #1;
    chk("b2b_rdy3", 32'(in_ready), 32'h1);
    tick();
    chk("b2b_v3", 32'(out_valid[0]), 32'h1);
    chk("b2b_d3", 32'(chd(0)), 32'h33);
    chk("b2b_ch2_held", 32'(out_valid), 32'h5);
    chk("b2b_cnt", 32'(xfer_cnt), 32'h4);
    in_valid = 0;

    // round-robin wrap from a clean state
    rst = 1; tick(); rst = 0;
    mode = 1; out_ready = 4'b1111; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = rr_words[i]; #1;
      chk("rr_ready", 32'(in_ready), 32'h1);
      tick();
      chk("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      chk("rr_data",  32'(chd(i % 4)), 32'(rr_words[i]));
    end
    in_valid = 0;
    chk("rr_ptr_end", 32'(rr_ptr),   32'h1);
    chk("rr_cnt_end", 32'(xfer_cnt), 32'h5);

    // stall isolation, pointer starting at 0
    rst = 1; tick(); rst = 0;
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + W'(i);
      tick();
    end
    chk("stl_valid", 32'(out_valid), 32'hF);
    chk("stl_ptr",   32'(rr_ptr),    32'h0);
    in_data = 8'h14; #1;
    chk("stl_rdy0", 32'(in_ready), 32'h0);
    tick();
    chk("stl_noskip_ptr", 32'(rr_ptr),   32'h0);
    chk("stl_noskip_cnt", 32'(xfer_cnt), 32'h4);
    chk("stl_noskip_d0",  32'(chd(0)),   32'h10);
    out_ready = 4'b0001; #1;
    chk("stl_rdy1", 32'(in_ready), 32'h1);
    tick();
    out_ready = 0; in_valid = 0;
    chk("stl_d0",  32'(chd(0)),    32'h14);
    chk("stl_ptr1", 32'(rr_ptr),   32'h1);
    chk("stl_v",   32'(out_valid), 32'hF);
    chk("stl_d1",  32'(chd(1)),    32'h11);
    chk("stl_d2",  32'(chd(2)),    32'h12);
    chk("stl_d3",  32'(chd(3)),    32'h13);
    chk("stl_cnt", 32'(xfer_cnt),  32'h5);

    // drain channels 0 and 2, then reset with a word offered
    out_ready = 4'b0101; tick(); out_ready = 0;
    chk("mid_pre_valid", 32'(out_valid), 32'hA);
    in_sel = 0; mode = 0; in_valid = 1; in_data = 8'h77; rst = 1;
    tick();
    rst = 0; in_valid = 0;
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_ptr",   32'(rr_ptr),    32'h0);
    chk("mid_cnt",   32'(xfer_cnt),  32'h0);
    chk("mid_data",  32'(out_data),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
